// File: rtl/wav_cgc_pkg.sv
// wav_cgc_pkg: shared channel state encoding and counter sizing for the clock-gate controller
package wav_cgc_pkg;
  typedef enum logic [1:0] {OFF = 2'b00, WAKE = 2'b01, ON = 2'b10, HOLD = 2'b11} cgc_state_t;
  function automatic int cgc_cnt_w(input int wake, input int idle);
    int m;
    m = wake > idle ? wake : idle;
    return m == 0 ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/wav_cgc_ch_fsm.sv
// wav_cgc_ch_fsm: one channel's wake/hold sequencer with settle and idle-hysteresis counter
module wav_cgc_ch_fsm
  import wav_cgc_pkg::*;
#(
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req,
  input  logic i_force_on,
  output logic o_en,
  output logic o_ack,
  output logic o_idle_nxt
);
  localparam int CNT_W = cgc_cnt_w(WAKE_CYC, IDLE_CYC);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC > 0 ? WAKE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC > 0 ? IDLE_CYC - 1 : 0);
  cgc_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_en, r_ack;
  logic w_act;
  assign w_act = i_req | i_force_on;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt == '0 ? r_cnt : r_cnt - 1'b1;
    case (r_state)
      OFF: if (w_act) begin
        w_state_nxt = WAKE_CYC == 0 ? ON : WAKE;
        w_cnt_nxt = WAKE_LD;
      end
      WAKE: w_state_nxt = r_cnt == '0 ? ON : WAKE;
      ON: if (!w_act) begin
        w_state_nxt = IDLE_CYC == 0 ? OFF : HOLD;
        w_cnt_nxt = IDLE_LD;
      end
      HOLD: w_state_nxt = w_act ? ON : (r_cnt == '0 ? OFF : HOLD);
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= OFF;
      r_cnt <= '0;
      r_en <= 1'b0;
      r_ack <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_en <= w_state_nxt != OFF;
      r_ack <= (w_state_nxt == ON) & i_req;
    end
  end
  assign o_en = r_en;
  assign o_ack = r_ack;
  assign o_idle_nxt = w_state_nxt == OFF;
endmodule

// File: rtl/wav_cgc_rl.sv
// wav_cgc_rl: low-transparent latch clock gate, glitch-free, with scan bypass
module wav_cgc_rl (
  input  logic i_clk,
  input  logic i_clk_en,
  input  logic i_test_en,
  output logic o_clk
);
  logic r_en;
  always_latch begin
    if (!i_clk) r_en <= i_clk_en | i_test_en;
  end
  assign o_clk = i_clk & r_en;
endmodule

// File: rtl/wav_cgc_mc_ctrl.sv
// wav_cgc_mc_ctrl: N independent req/ack clock-gate channels plus an all-idle status flag
module wav_cgc_mc_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_test_en,
  input  logic [NUM_CH-1:0] i_req,
  input  logic [NUM_CH-1:0] i_force_on,
  output logic [NUM_CH-1:0] o_ack,
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_clk_en,
  output logic              o_all_idle
);
  logic [NUM_CH-1:0] w_idle_nxt;
  logic r_all_idle;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wav_cgc_ch_fsm #(.WAKE_CYC(WAKE_CYC), .IDLE_CYC(IDLE_CYC)) u_fsm (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_req      (i_req[g]),
      .i_force_on (i_force_on[g]),
      .o_en       (o_clk_en[g]),
      .o_ack      (o_ack[g]),
      .o_idle_nxt (w_idle_nxt[g])
    );
    wav_cgc_rl u_rl (
      .i_clk     (i_clk),
      .i_clk_en  (o_clk_en[g]),
      .i_test_en (i_test_en),
      .o_clk     (o_clk[g])
    );
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_all_idle <= 1'b1;
    else r_all_idle <= &w_idle_nxt;
  end
  assign o_all_idle = r_all_idle;
endmodule
